// File: rtl/instr_fetch_unit_pkg.sv
// Shared pipeline definitions for the fetch stage and the IF/ID register.
package instr_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: redirect/hazard controls, instruction memory link and IF/ID outputs.
// fetch_fault exists only when PC_BOUND_CHECK_EN is defined.
interface instr_fetch_unit_if;

  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] instr_in;
  logic [31:0] pc_out;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
`ifdef PC_BOUND_CHECK_EN
  logic        fetch_fault;
`endif

  modport master (
    input  stall, flush, branch_taken, branch_target, jump, jump_target, instr_in,
`ifdef PC_BOUND_CHECK_EN
    output fetch_fault,
`endif
    output pc_out, if_id_instr, if_id_pc4, if_id_valid
  );

  modport slave (
    output stall, flush, branch_taken, branch_target, jump, jump_target, instr_in,
`ifdef PC_BOUND_CHECK_EN
    input  fetch_fault,
`endif
    input  pc_out, if_id_instr, if_id_pc4, if_id_valid
  );

endinterface

// File: rtl/instr_fetch_unit_if_id_reg.sv
// Pipeline register with bubble > hold > load priority; shared pattern for later stage registers.
module instr_fetch_unit_if_id_reg
  import instr_fetch_unit_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_flush,
  input  logic   i_stall,
  input  if_id_t i_load,
  output if_id_t o_q
);

  if_id_t r_q;
  if_id_t w_d;

  always_comb begin
    w_d = r_q;
    if (i_flush) begin
      w_d = IF_ID_BUBBLE;
    end else if (!i_stall) begin
      w_d = i_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= IF_ID_BUBBLE;
    end else begin
      r_q <= w_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, next-PC selection and IF/ID capture.
// Optional out-of-range fetch detection is enabled by defining PC_BOUND_CHECK_EN.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned MEM_WORDS = 64
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_unit_if.master fetch_bus
);

  if (RESET_PC[1:0] != 2'b00 || MEM_WORDS == 0) begin : g_param_check
    $error("instr_fetch_unit: RESET_PC must be word aligned and MEM_WORDS nonzero");
  end

  logic [31:0] r_pc;
  logic [31:0] w_next_pc;
  logic [31:0] w_pc4;
  logic        w_redirect;
  logic        w_bubble;
  if_id_t      w_load;
  if_id_t      w_if_id;

  assign w_pc4      = r_pc + PC_INCR;
  assign w_redirect = fetch_bus.jump | fetch_bus.branch_taken;

  // Redirects take precedence over stall so a resolved branch is never lost.
  always_comb begin
    w_next_pc = w_pc4;
    if (fetch_bus.jump) begin
      w_next_pc = align_word(fetch_bus.jump_target);
    end else if (fetch_bus.branch_taken) begin
      w_next_pc = align_word(fetch_bus.branch_target);
    end else if (fetch_bus.stall) begin
      w_next_pc = r_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

`ifdef PC_BOUND_CHECK_EN
  logic w_oob;
  logic r_fault;

  assign w_oob = ({2'b00, w_next_pc[31:2]} >= MEM_WORDS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault <= 1'b0;
    end else begin
      r_fault <= r_fault | w_oob;
    end
  end

  assign fetch_bus.fetch_fault = r_fault;
  assign w_bubble              = fetch_bus.flush | w_redirect | w_oob;
`else
  assign w_bubble = fetch_bus.flush | w_redirect;
`endif

  assign w_load = '{instr: fetch_bus.instr_in, pc4: w_pc4, valid: 1'b1};

  instr_fetch_unit_if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_bubble),
    .i_stall (fetch_bus.stall),
    .i_load  (w_load),
    .o_q     (w_if_id)
  );

  assign fetch_bus.pc_out      = r_pc;
  assign fetch_bus.if_id_instr = w_if_id.instr;
  assign fetch_bus.if_id_pc4   = w_if_id.pc4;
  assign fetch_bus.if_id_valid = w_if_id.valid;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + randomized bench for instr_fetch_unit against a spec-level reference model.
// Fault checks are compiled in when PC_BOUND_CHECK_EN is defined.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int unsigned WORDS  = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic        m_fault;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC  (RST_PC),
    .MEM_WORDS (WORDS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_bus (bus)
  );

  always #5 clk = ~clk;

  // Word k of the memory image holds 32'h1000_0000 + k.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign bus.instr_in = mem_word(bus.pc_out);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc_out"}, bus.pc_out, m_pc);
    chk({tag, ".instr"}, bus.if_id_instr, m_instr);
    chk({tag, ".pc4"}, bus.if_id_pc4, m_pc4);
    chk({tag, ".valid"}, {31'b0, bus.if_id_valid}, {31'b0, m_valid});
`ifdef PC_BOUND_CHECK_EN
    chk({tag, ".fault"}, {31'b0, bus.fetch_fault}, {31'b0, m_fault});
`endif
  endtask

  task automatic model_reset();
    m_pc    = RST_PC;
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
    m_fault = 1'b0;
  endtask

  // One clock: drive inputs, predict the post-edge state from the rules, then compare.
  task automatic step(input string tag, input logic st, input logic fl, input logic br,
                      input logic [31:0] bt, input logic jp, input logic [31:0] jt);
    logic [31:0] npc;
    bit          bub;
    bus.stall         = st;
    bus.flush         = fl;
    bus.branch_taken  = br;
    bus.branch_target = bt;
    bus.jump          = jp;
    bus.jump_target   = jt;
    if (jp)      npc = jt - (jt % 4);
    else if (br) npc = bt - (bt % 4);
    else if (st) npc = m_pc;
    else         npc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
    bub = fl || jp || br;
`ifdef PC_BOUND_CHECK_EN
    if ((npc / 4) >= WORDS) begin
      bub     = 1'b1;
      m_fault = 1'b1;
    end
`endif
    if (bub) begin
      m_instr = 32'h0;
      m_pc4   = 32'h0;
      m_valid = 1'b0;
    end else if (!st) begin
      m_instr = mem_word(m_pc);
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
    end
    m_pc = npc;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    bus.stall         = 1'b0;
    bus.flush         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;
    bus.jump          = 1'b0;
    bus.jump_target   = 32'h0;
    model_reset();
    #1;
    check_all("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all("reset_release");

    // Free run, then a two-cycle stall at pc 8.
    run("freerun", 2);
    chk("freerun.pc_is_8", bus.pc_out, 32'h8);
    step("stall", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("stall", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("stall.hold_instr", bus.if_id_instr, 32'h1000_0001);
    run("unstall", 1);
    chk("unstall.pc_is_12", bus.pc_out, 32'd12);
    run("freerun2", 1);

    // Branch beats stall, target low bits dropped; then word 8 loads.
    step("br_stall", 1'b1, 1'b0, 1'b1, 32'h0000_0022, 1'b0, 32'h0);
    chk("br_stall.pc", bus.pc_out, 32'h20);
    run("after_br", 1);
    chk("after_br.instr", bus.if_id_instr, 32'h1000_0008);

    // Jump beats branch; flush with stall holds the PC.
    step("jmp_br", 1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 32'h40);
    chk("jmp_br.pc", bus.pc_out, 32'h40);
    run("after_jmp", 1);
    step("stall_flush", 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step("flush", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

    // Walk off the end of memory, then jump back in.
    step("to_f8", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hF8);
    run("edge_mem", 3);
    step("back_0", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    run("resume", 2);

    // 32-bit PC wrap.
    step("to_top", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
    run("wrap", 2);
    chk("wrap.pc", bus.pc_out, 32'h4);

    // Reset mid-run with a branch pending.
    step("to_10", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10);
    run("to_18", 2);
    chk("to_18.pc", bus.pc_out, 32'h18);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h80;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    bus.branch_taken = 1'b0;
    rst_n = 1'b1;
    check_all("post_rst");
    run("post_rst_fetch", 2);

    // Randomized traffic with mostly in-range targets.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) == 0),
           32'($urandom_range(0, 80) * 4 + $urandom_range(0, 3)),
           ($urandom_range(0, 11) == 0),
           32'($urandom_range(0, 80) * 4 + $urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory interface: owns the program counter and drives the word-aligned fetch address to the combinational instruction memory.
- Captures the returned instruction word into the IF/ID pipeline register.
- Handles pipeline stall, flush and branch/jump redirect from later stages.
- Sits between instruction memory and the decode stage of the 5-stage pipeline.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- MEM_WORDS, 64, instruction memory depth in 32-bit words; used only by the optional bound check.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hazard unit: hold PC and IF/ID.
- flush  input  1  clear IF/ID to a bubble.
- branch_taken  input  1  conditional branch resolved taken.
- branch_target  input  32  branch destination address.
- jump  input  1  unconditional jump.
- jump_target  input  32  jump destination address.
- instr_in  input  32  instruction word from instruction memory for the current pc_out.
- pc_out  output  32  fetch byte address to instruction memory; memory indexes with [31:2].
- if_id_instr  output  32  latched instruction for decode.
- if_id_pc4  output  32  latched PC+4 of that instruction.
- if_id_valid  output  1  IF/ID holds a real instruction.
- fetch_fault  output  1  present only with PC_BOUND_CHECK_EN; out-of-range fetch.

Behaviour:
- Reset (async, rst_n=0):
  - pc_out = RESET_PC.
  - if_id_instr = 32'h0000_0000 (NOP).
  - if_id_pc4 = 0.
  - if_id_valid = 0.
  - fetch_fault = 0.
- Memory read is combinational, so instr_in is valid in the same cycle as pc_out. Fetch latency is 1 clock: the address is presented in cycle N and the instruction appears at if_id_* after edge N+1.
- redirect = jump | branch_taken.
- Next-PC priority, evaluated at each rising edge:
  1. jump → {jump_target[31:2], 2'b00}.
  2. branch_taken → {branch_target[31:2], 2'b00}.
  3. stall → pc_out unchanged.
  4. Otherwise → pc_out + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Redirect overrides stall. The resolving stage asserts redirect only when its own instruction is valid.
- IF/ID update priority per edge:
  1. flush | redirect → bubble: instr = 0, pc4 = 0, valid = 0.
  2. stall → hold all three fields.
  3. Otherwise → instr = instr_in, pc4 = pc_out + 4, valid = 1.
- Simultaneous stall and flush: flush wins; the bubble is inserted and the PC holds unless redirect is also asserted.
- Target bits [1:0] are silently forced to 00; no trap is raised.
- Reset asserted mid-operation aborts any pending redirect. The first fetch after rst_n deasserts is from RESET_PC.
- No internal FSM beyond the PC and IF/ID registers. The state is effectively {RUN, HOLD}, selected per cycle by stall.

Optional Feature:
- Macro: PC_BOUND_CHECK_EN.
- Defined:
  - fetch_fault is a registered flag, set at the edge where the next PC satisfies next_pc[31:2] >= MEM_WORDS.
  - The same edge loads IF/ID with a bubble (valid = 0) instead of instr_in.
  - fetch_fault stays sticky until reset.
  - The PC still advances or redirects normally, so a later redirect back into range resumes fetching; fault remains 1.
- Undefined: the fetch_fault port and its logic are absent, and an out-of-range PC fetches whatever the memory returns.

Decomposition:
- Shared pipeline package holds:
  - NOP_INSTR = 32'h0000_0000.
  - PC_INCR = 4.
  - Default RESET_PC.
  - Struct/typedef for the IF/ID bundle {instr, pc4, valid}.
- One natural sub-module: if_id_reg, which implements the bubble/hold/load register with flush and stall priority. It is reused by the later ID/EX register pattern.
- PC next-state logic stays in instr_fetch_unit.

Test Plan:
- Reset then 4 free-run cycles, memory preloaded with word k = 32'h1000_0000+k → pc_out 0,4,8,12,16; IF/ID shows instr 32'h1000_0000..03 with pc4 4..16, valid=1 from the first edge.
- stall=1 for 2 cycles at pc_out=8 → pc_out stays 8; if_id_instr holds 32'h1000_0001; on release pc_out=12 next edge.
- branch_taken=1, branch_target=32'h0000_0022 with stall=1 → next pc_out=32'h20; IF/ID bubble (valid=0, instr=0); next edge loads word 8.
- jump=1 (target 32'h40) together with branch_taken=1 (target 32'h20) → pc_out=32'h40.
- PC at 32'hFFFF_FFFC free-running → wraps to 0. With PC_BOUND_CHECK_EN and MEM_WORDS=64: PC stepping 32'hFC→32'h100 sets fetch_fault=1 and valid=0 at that edge; fault stays 1 after jump to 0.
- rst_n pulled low mid-run at pc_out=32'h18 with branch_taken pending → outputs return to reset values immediately; first post-reset fetch at RESET_PC.
